// File: rtl/move_controller.sv
// move_controller: sequences move placement, turn alternation and board clearing for the point registers
module move_controller #(
    parameter int BOARD_SIZE = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       move_req,
    input  logic [3:0] move_x,
    input  logic [3:0] move_y,
    input  logic       clear_req,
    input  logic       game_over,
    input  logic [1:0] cell_q,
    output logic [3:0] cell_x,
    output logic [3:0] cell_y,
    output logic       wr_en,
    output logic [1:0] wr_d,
    output logic       move_ack,
    output logic       move_ok,
    output logic       clear_done,
    output logic [1:0] turn,
    output logic [7:0] move_count,
    output logic       board_full,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, CLEAR} state_t;

    localparam logic [3:0] LAST = 4'(BOARD_SIZE - 1);
    localparam logic [7:0] AREA = 8'(BOARD_SIZE * BOARD_SIZE);

    state_t     state, state_n;
    logic [3:0] x_n, y_n;
    logic       wr_en_n, ack_n, ok_n, done_n, full_n;
    logic [1:0] wr_d_n, turn_n;
    logic [7:0] count_n;
    logic       reject;

    assign reject = (cell_x > LAST) || (cell_y > LAST) || (cell_q != 2'b00) || game_over || board_full;
    assign busy   = state != IDLE;

    // next-state and next-output decode; every output is registered below
    always_comb begin
        state_n = state;
        x_n     = cell_x;
        y_n     = cell_y;
        wr_en_n = 1'b0;
        wr_d_n  = wr_d;
        ack_n   = 1'b0;
        ok_n    = 1'b0;
        done_n  = 1'b0;
        turn_n  = turn;
        count_n = move_count;
        full_n  = board_full;
        case (state)
            IDLE: begin
                if (!move_ack && !clear_done && clear_req) begin
                    state_n = CLEAR;
                    x_n     = 4'd0;
                    y_n     = 4'd0;
                    wr_en_n = 1'b1;
                    wr_d_n  = 2'b00;
                end else if (!move_ack && !clear_done && move_req) begin
                    state_n = READ;
                    x_n     = move_x;
                    y_n     = move_y;
                end
            end
            READ: state_n = CHECK;
            CHECK: begin
                state_n = reject ? IDLE : WRITE;
                ack_n   = reject;
                wr_en_n = !reject;
                wr_d_n  = reject ? wr_d : turn;
            end
            WRITE: begin
                state_n = IDLE;
                ack_n   = 1'b1;
                ok_n    = 1'b1;
                turn_n  = ~turn;
                count_n = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
                full_n  = count_n == AREA;
            end
            CLEAR: begin
                if (cell_x == LAST && cell_y == LAST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    turn_n  = 2'b10;
                    count_n = 8'd0;
                    full_n  = 1'b0;
                end else begin
                    wr_en_n = 1'b1;
                    wr_d_n  = 2'b00;
                    x_n     = (cell_x == LAST) ? 4'd0 : cell_x + 4'd1;
                    y_n     = (cell_x == LAST) ? cell_y + 4'd1 : cell_y;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset aborts any operation without an ack or done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cell_x     <= 4'd0;
            cell_y     <= 4'd0;
            wr_en      <= 1'b0;
            wr_d       <= 2'b00;
            move_ack   <= 1'b0;
            move_ok    <= 1'b0;
            clear_done <= 1'b0;
            turn       <= 2'b10;
            move_count <= 8'd0;
            board_full <= 1'b0;
        end else begin
            state      <= state_n;
            cell_x     <= x_n;
            cell_y     <= y_n;
            wr_en      <= wr_en_n;
            wr_d       <= wr_d_n;
            move_ack   <= ack_n;
            move_ok    <= ok_n;
            clear_done <= done_n;
            turn       <= turn_n;
            move_count <= count_n;
            board_full <= full_n;
        end
    end
endmodule

// File: doc/move_controller.md
# move_controller

Sequencer that owns write access to the game-board point registers. It accepts move requests, reads the addressed point and accepts or rejects the move, writes the current player's colour, alternates turns, and counts moves. It also sweeps the whole board to empty for a new game. It sits between the input/cursor logic and the board storage array.

## Interface
- BOARD_SIZE, 15, points per row/column (1..15); coordinates are 4 bits
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all controller state (board cells have their own reset)
- move_req  in  1  level request; held by requester until move_ack
- move_x  in  4  requested column; sampled only when request is accepted
- move_y  in  4  requested row; sampled only when request is accepted
- clear_req  in  1  start new-game board sweep
- game_over  in  1  from win detector; when 1, every move is rejected
- cell_q  in  2  state of point at (cell_x, cell_y): 00 empty, 01 white, 10 black; valid one cycle after address changes
- cell_x  out  4  board column address (registered)
- cell_y  out  4  board row address (registered)
- wr_en  out  1  write strobe to addressed point (registered)
- wr_d  out  2  data written to addressed point (registered)
- move_ack  out  1  one-cycle pulse: move request resolved
- move_ok  out  1  valid with move_ack: 1 = stone placed, 0 = rejected
- clear_done  out  1  one-cycle pulse: sweep finished
- turn  out  2  colour to move next: 10 black, 01 white
- move_count  out  8  stones placed since reset/clear
- board_full  out  1  move_count == BOARD_SIZE*BOARD_SIZE
- busy  out  1  state != IDLE

## Operation
- Reset values:
  - State IDLE.
  - cell_x/cell_y 0, wr_en 0, wr_d 00.
  - move_ack/move_ok/clear_done 0.
  - turn 10 (black first), move_count 0, board_full 0, busy 0.
- States: IDLE, READ, CHECK, WRITE, CLEAR.
- IDLE:
  - Requests are ignored in any cycle where move_ack or clear_done is 1.
  - clear_req=1: go to CLEAR; cell_x=cell_y=0. clear_req wins over a simultaneous move_req.
  - Else move_req=1: latch move_x/move_y into cell_x/cell_y; go to READ.
- READ: wait one cycle for cell_q to become valid; go to CHECK.
- CHECK: reject if any of the following holds.
  - cell_x ≥ BOARD_SIZE or cell_y ≥ BOARD_SIZE
  - cell_q != 00
  - game_over=1
  - board_full=1
  - On reject: next cycle move_ack=1, move_ok=0; go to IDLE; turn and count unchanged.
  - Otherwise: wr_en=1, wr_d=turn; go to WRITE.
- WRITE: the point is written at this edge. Next cycle:
  - wr_en=0, move_ack=1, move_ok=1.
  - turn toggles (10↔01).
  - move_count+1, saturating at 255.
  - Go to IDLE.
- CLEAR:
  - Every cycle: wr_en=1, wr_d=00 at (cell_x, cell_y).
  - Advance row-major: x increments; at BOARD_SIZE-1, x wraps to 0 and y increments.
  - After writing (BOARD_SIZE-1, BOARD_SIZE-1): wr_en=0, clear_done=1, turn=10, move_count=0, board_full=0; go to IDLE.
  - move_req is ignored throughout the sweep.
- board_full is registered and updated in the same cycle as move_count.
- game_over is sampled only in CHECK.
- Reset asserted mid-operation:
  - Aborts immediately; all outputs take reset values.
  - No ack or clear_done pulse is produced for the aborted operation.

## Timing
- Accept edge = cycle 0 (IDLE samples move_req).
- READ in cycle 1, CHECK in cycle 2.
- Reject: move_ack in cycle 3.
- Accept: wr_en high in cycle 3, move_ack/move_ok in cycle 4; turn and move_count updated in cycle 4.
- Earliest next accept: the cycle after move_ack. Requester must drop move_req in the ack cycle.
- Clear: clear_req sampled in cycle 0.
  - wr_en high for BOARD_SIZE² consecutive cycles, starting at cycle 1.
  - clear_done in cycle BOARD_SIZE²+1.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then request (3,4) with cell_q=00: wr_en=1, wr_d=10 at cell (3,4) in cycle 3. Cycle 4: move_ack=1, move_ok=1, turn=01, move_count=1.
- Request (3,4) with cell_q=10: move_ack in cycle 3 with move_ok=0; no wr_en; turn and count unchanged.
- Requests (15,0) with BOARD_SIZE=15, and any move with game_over=1: each rejected, move_ok=0.
- clear_req and move_req high together:
  - Sweep wins.
  - 225 consecutive wr_en cycles with wr_d=00, addresses (0,0),(1,0)…(14,14).
  - clear_done pulses once; turn=10, move_count=0.
- Fill with BOARD_SIZE=2 (4 accepted moves): board_full=1 with the 4th ack; 5th request rejected. Turn sequence 10,01,10,01,10.
- Assert reset during WRITE and during CLEAR at (5,2): outputs return to reset values; no ack or clear_done pulse; a fresh request afterwards completes normally.
